// File: rtl/floatingpoint_pkg.sv
// Shared IEEE-754 single-precision definitions: field widths, integer limits,
// classification helpers and the float_to_int FSM state type.
package floatingpoint;

  localparam int INT_BITS      = 32;
  localparam int EXPONENT_BITS = 8;
  localparam int FRACTION_BITS = 23;
  localparam int BIAS          = 127;

  localparam logic [INT_BITS-1:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [INT_BITS-1:0] INT_MIN = 32'h8000_0000;

  typedef struct packed {
    logic                     sign;
    logic [EXPONENT_BITS-1:0] exponent;
    logic [FRACTION_BITS-1:0] fraction;
  } float_t;

  typedef enum logic [1:0] {IDLE, SHIFT, SIGN, DONE} f2i_state_t;

  function automatic logic iszero(input float_t f);
    return (f.exponent == '0) && (f.fraction == '0);
  endfunction

  function automatic logic isdenorm(input float_t f);
    return (f.exponent == '0) && (f.fraction != '0);
  endfunction

  function automatic logic isnan(input float_t f);
    return (f.exponent == '1) && (f.fraction != '0);
  endfunction

  function automatic logic isinfinity(input float_t f);
    return (f.exponent == '1) && (f.fraction == '0);
  endfunction

endpackage

// File: rtl/float_to_int_if.sv
// Operand/result handshake bundle for float_to_int; master is the producer/consumer side.
interface float_to_int_if;
  import floatingpoint::*;

  logic                in_valid;
  logic                in_ready;
  float_t              in_float;
  logic                out_valid;
  logic                out_ready;
  logic [INT_BITS-1:0] result;
  logic                invalid;
  logic                inexact;

  modport master (
    output in_valid, in_float, out_ready,
    input  in_ready, out_valid, result, invalid, inexact
  );

  modport slave (
    input  in_valid, in_float, out_ready,
    output in_ready, out_valid, result, invalid, inexact
  );

endinterface

// File: rtl/float_to_int.sv
// Multi-cycle float -> int32 converter, truncating toward zero. The mantissa is
// aligned one bit per cycle, so latency depends on the exponent.
module float_to_int
  import floatingpoint::*;
(
  input  logic          clk,
  input  logic          reset,
  float_to_int_if.slave bus
);

  localparam logic [EXPONENT_BITS-1:0] EXP_ONE  = EXPONENT_BITS'(BIAS);
  localparam logic [EXPONENT_BITS-1:0] EXP_OVF  = EXPONENT_BITS'(BIAS + 31);
  localparam logic [4:0]               MANT_POS = 5'(FRACTION_BITS);
  localparam float_t                   NEG_2_31 = 32'hCF00_0000;

  f2i_state_t          state;
  logic [INT_BITS-1:0] mag;
  logic [INT_BITS-1:0] result_q;
  logic [4:0]          cnt;
  logic                shift_left;
  logic                sticky;
  logic                sign_q;
  logic                invalid_q;
  logic                inexact_q;

  float_t              f;
  logic [4:0]          e_unb;
  logic                accept;

  logic                spec_hit;
  logic [INT_BITS-1:0] spec_res;
  logic                spec_inv;
  logic                spec_inx;

  assign f      = bus.in_float;
  assign e_unb  = 5'(f.exponent - EXP_ONE);
  assign accept = bus.in_valid && (state == IDLE);

  // Operands whose result is known without alignment skip straight to DONE.
  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    spec_inv = 1'b0;
    spec_inx = 1'b0;
    if (isnan(f)) begin
      spec_res = INT_MIN;
      spec_inv = 1'b1;
    end else if (isinfinity(f)) begin
      spec_res = f.sign ? INT_MIN : INT_MAX;
      spec_inv = 1'b1;
    end else if (iszero(f)) begin
      spec_inx = 1'b0;
    end else if (isdenorm(f) || (f.exponent < EXP_ONE)) begin
      spec_inx = 1'b1;
    end else if (f == NEG_2_31) begin
      spec_res = INT_MIN;
    end else if (f.exponent >= EXP_OVF) begin
      spec_res = f.sign ? INT_MIN : INT_MAX;
      spec_inv = 1'b1;
    end else begin
      spec_hit = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mag        <= '0;
      result_q   <= '0;
      cnt        <= '0;
      shift_left <= 1'b0;
      sticky     <= 1'b0;
      sign_q     <= 1'b0;
      invalid_q  <= 1'b0;
      inexact_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign_q <= f.sign;
          sticky <= 1'b0;
          if (spec_hit) begin
            result_q  <= spec_res;
            invalid_q <= spec_inv;
            inexact_q <= spec_inx;
            state     <= DONE;
          end else begin
            // Hidden bit sits at position 23; move it to position E.
            mag        <= INT_BITS'({1'b1, f.fraction});
            shift_left <= (e_unb > MANT_POS);
            cnt        <= (e_unb > MANT_POS) ? e_unb - MANT_POS : MANT_POS - e_unb;
            state      <= (e_unb == MANT_POS) ? SIGN : SHIFT;
          end
        end
        SHIFT: begin
          if (shift_left) begin
            mag <= mag << 1;
          end else begin
            mag    <= mag >> 1;
            sticky <= sticky | mag[0];
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= SIGN;
        end
        SIGN: begin
          result_q  <= sign_q ? -mag : mag;
          invalid_q <= 1'b0;
          inexact_q <= sticky;
          state     <= DONE;
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.invalid   = invalid_q;
  assign bus.inexact   = inexact_q;

endmodule
